anim_mode_ctrl: RTL and testbench

//  Upstream control stage for the LED animation selector: turns three raw push-buttons

---
 rtl/anim_mode_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_anim_mode_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anim_mode_ctrl.sv
// ----------------------------------------------------------------------------
// anim_mode_ctrl
//   Control stage in front of the LED animation mux. Three raw push-buttons
//   are synchronised, debounced into single-cycle press pulses, and used to
//   step the animation mode (with wrap) and toggle the output enable. An
//   optional auto-advance timer steps the mode forward on a fixed period.
//
//   Parameters
//     NUM_MODES    number of valid modes (2..8), mode range 0..NUM_MODES-1
//     DEB_CYCLES   stable cycles needed before a level change is accepted
//     AUTO_PERIOD  cycles between automatic mode advances
//
//   Ports
//     clk       system clock, rising edge
//     rst       asynchronous, active-low reset
//     btn_next  raw async button: step mode forward
//     btn_prev  raw async button: step mode backward
//     btn_en    raw async button: toggle en
//     auto_sel  synchronous level, 1 enables auto-advance
//     mode      registered animation mode
//     en        registered animation enable
//     mode_chg  one-cycle pulse in the cycle mode takes a new value
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// anim_mode_deb
//   Debounce FSM for one synchronised button. Emits a registered one-cycle
//   press pulse after DEB_CYCLES+1 consecutive high samples, then requires the
//   same amount of quiet low time before another press can be armed. A short
//   return high while releasing drops back to HELD without a new pulse.
//
//   Ports
//     clk, rst  clock / async active-low reset
//     sync_in   synchronised button level
//     press     one-cycle pulse per accepted press
// ----------------------------------------------------------------------------
module anim_mode_deb #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HELD,
        DISARM
    } deb_state_t;

    deb_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          press_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            press <= press_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (sync_in) begin
                    state_nxt = ARM;
                    cnt_nxt   = '0;
                end
            end
            ARM: begin
                // a drop while arming abandons the press entirely
                if (!sync_in) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!sync_in) begin
                    state_nxt = DISARM;
                    cnt_nxt   = '0;
                end
            end
            DISARM: begin
                // release bounce: go back to HELD, no second pulse
                if (sync_in) begin
                    state_nxt = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

module anim_mode_ctrl #(
    parameter int NUM_MODES   = 5,
    parameter int DEB_CYCLES  = 16,
    parameter int AUTO_PERIOD = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_en,
    input  logic       auto_sel,
    output logic [2:0] mode,
    output logic       en,
    output logic       mode_chg
);

    localparam int NUM_BTN = 3;
    localparam int BTN_NEXT = 0;
    localparam int BTN_PREV = 1;
    localparam int BTN_EN   = 2;
    localparam int AW = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [2:0]    MODE_LAST = 3'(NUM_MODES - 1);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronisers, one per button
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] sync_a;
    logic [NUM_BTN-1:0] sync_b;
    logic [NUM_BTN-1:0] press;

    assign btn_raw = {btn_en, btn_prev, btn_next};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    // ------------------------------------------------------------------
    // Debouncers
    // ------------------------------------------------------------------
    anim_mode_deb #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb [NUM_BTN-1:0] (
        .clk    (clk),
        .rst    (rst),
        .sync_in(sync_b),
        .press  (press)
    );

    logic press_next;
    logic press_prev;
    logic press_en;

    assign press_next = press[BTN_NEXT];
    assign press_prev = press[BTN_PREV];
    assign press_en   = press[BTN_EN];

    // ------------------------------------------------------------------
    // Auto-advance timer: runs only while auto_sel and en are both set.
    // A manual step restarts the full period so an auto step never lands
    // right after the user picked a mode.
    // ------------------------------------------------------------------
    logic [AW-1:0] auto_cnt;
    logic          auto_run;
    logic          auto_tick;

    assign auto_run  = auto_sel & en;
    assign auto_tick = auto_run && (auto_cnt == AUTO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            auto_cnt <= '0;
        end else if (!auto_run || press_next || press_prev || auto_tick) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Mode stepping. Opposing manual presses cancel; any manual press
    // takes priority over the auto tick so at most one step happens.
    // ------------------------------------------------------------------
    logic       step_fwd;
    logic       step_back;
    logic [2:0] mode_nxt;

    always_comb begin
        step_fwd  = 1'b0;
        step_back = 1'b0;
        if (press_next && !press_prev) begin
            step_fwd = 1'b1;
        end else if (press_prev && !press_next) begin
            step_back = 1'b1;
        end else if (!press_next && !press_prev && auto_tick) begin
            step_fwd = 1'b1;
        end

        mode_nxt = mode;
        if (step_fwd) begin
            mode_nxt = (mode == MODE_LAST) ? 3'd0 : mode + 3'd1;
        end else if (step_back) begin
            mode_nxt = (mode == 3'd0) ? MODE_LAST : mode - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode     <= 3'd0;
            en       <= 1'b0;
            mode_chg <= 1'b0;
        end else begin
            mode     <= mode_nxt;
            mode_chg <= (mode_nxt != mode);
            en       <= en ^ press_en;
        end
    end

endmodule

// File: tb/tb_anim_mode_ctrl.sv
module tb_anim_mode_ctrl;

    localparam int NM  = 5;
    localparam int DEB = 5;
    localparam int AP  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       btn_en = 1'b0;
    logic       auto_sel = 1'b0;
    logic [2:0] mode;
    logic       en;
    logic       mode_chg;

    anim_mode_ctrl #(
        .NUM_MODES  (NM),
        .DEB_CYCLES (DEB),
        .AUTO_PERIOD(AP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_next(btn_next),
        .btn_prev(btn_prev),
        .btn_en  (btn_en),
        .auto_sel(auto_sel),
        .mode    (mode),
        .en      (en),
        .mode_chg(mode_chg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int at;
        int val;
    } ev_t;

    ev_t mq[$];   // expected mode changes: edge index, new mode
    ev_t eq[$];   // expected en changes: edge index, new en
    ev_t pq[$];   // accepted presses: edge at which they act, button index

    // reference model state
    int m_mode, m_en, m_since;
    int hi_run[3];
    int lo_run[3];
    bit released[3];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model. Works on raw samples: a press is accepted once the
    // button has been high for DEB+1 consecutive samples, provided it has
    // been low for at least DEB+1 consecutive samples since the previous
    // accepted press. It reaches the mode/en registers 3 edges later
    // (2 synchroniser flops + registered pulse).
    initial begin : model
        bit raw[3];
        bit pn, pp, pe, tick, act;
        int old;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                m_mode = 0; m_en = 0; m_since = 0;
                for (int i = 0; i < 3; i++) begin
                    hi_run[i] = 0; lo_run[i] = 0; released[i] = 1'b1;
                end
                pq.delete(); mq.delete(); eq.delete();
            end else begin
                raw[0] = btn_next; raw[1] = btn_prev; raw[2] = btn_en;
                for (int i = 0; i < 3; i++) begin
                    if (raw[i]) begin
                        hi_run[i]++; lo_run[i] = 0;
                    end else begin
                        lo_run[i]++; hi_run[i] = 0;
                        if (lo_run[i] >= DEB + 1) released[i] = 1'b1;
                    end
                    if (raw[i] && released[i] && hi_run[i] == DEB + 1) begin
                        released[i] = 1'b0;
                        pq.push_back('{cyc + 3, i});
                    end
                end
                pn = 0; pp = 0; pe = 0;
                while (pq.size() > 0 && pq[0].at == cyc) begin
                    case (pq[0].val)
                        0: pn = 1;
                        1: pp = 1;
                        default: pe = 1;
                    endcase
                    void'(pq.pop_front());
                end
                act  = auto_sel && (m_en != 0);
                tick = act && (m_since == AP - 1);
                if (!act || pn || pp || tick) m_since = 0;
                else m_since++;
                old = m_mode;
                if (pn && !pp) m_mode = (m_mode + 1) % NM;
                else if (pp && !pn) m_mode = (m_mode + NM - 1) % NM;
                else if (!pn && !pp && tick) m_mode = (m_mode + 1) % NM;
                if (m_mode != old) mq.push_back('{cyc, m_mode});
                if (pe) begin
                    m_en = (m_en != 0) ? 0 : 1;
                    eq.push_back('{cyc, m_en});
                end
            end
        end
    end

    // Monitor: consumes expected events whenever the DUT shows a change.
    initial begin : monitor
        logic last_en;
        bit   exp_c;
        last_en = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                last_en = en;
                continue;
            end
            while (mq.size() > 0 && mq[0].at < cyc) begin
                total++; bad++;
                $display("FAIL mode_missed: got none expected mode %0d at cycle %0d", mq[0].val, mq[0].at);
                void'(mq.pop_front());
            end
            exp_c = (mq.size() > 0 && mq[0].at == cyc);
            if (exp_c) begin
                check("mode_chg_pulse", mode_chg, 1);
                check("mode_value", mode, mq[0].val);
                void'(mq.pop_front());
            end else if (mode_chg !== 1'b0) begin
                check("spurious_mode_chg", mode_chg, 0);
            end
            if (eq.size() > 0 && eq[0].at == cyc) begin
                check("en_value", en, eq[0].val);
                void'(eq.pop_front());
            end else if (en !== last_en) begin
                check("spurious_en", en, last_en);
            end
            last_en = en;
            if (cyc % 16 == 0) check("mode_track", mode, m_mode);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(int b, logic v);
        case (b)
            0: btn_next = v;
            1: btn_prev = v;
            default: btn_en = v;
        endcase
    endtask

    // high for exactly 'hold' samples, then low for 'gap'
    task automatic press(int b, int hold, int gap);
        @(negedge clk);
        set_btn(b, 1'b1);
        cycles(hold);
        set_btn(b, 1'b0);
        cycles(gap);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        btn_next = 1'b0; btn_prev = 1'b0; btn_en = 1'b0;
        #1;
        check("rst_mode", mode, 0);
        check("rst_en", en, 0);
        check("rst_mode_chg", mode_chg, 0);
        cycles(2);
        #2;
        rst = 1'b1;
    endtask

    initial begin : stim
        int saved, n, tgt, k;
        int rem[3];
        logic lvl[3];

        // power-on reset
        #1 rst = 1'b0;
        #1;
        check("por_mode", mode, 0);
        check("por_en", en, 0);
        check("por_mode_chg", mode_chg, 0);
        cycles(2);
        #2 rst = 1'b1;
        cycles(5);

        // short glitches are rejected, including the DEB-sample boundary
        press(0, DEB - 2, 20);
        check("glitch_short", mode, 0);
        press(0, DEB, 20);
        check("glitch_boundary", mode, 0);

        // first accepted press: exact latency and single-cycle pulse
        @(negedge clk);
        btn_next = 1'b1;
        cycles(DEB + 3);
        check("lat_early", mode_chg, 0);
        @(negedge clk);
        check("lat_pulse", mode_chg, 1);
        check("lat_mode", mode, 1);
        @(negedge clk);
        check("lat_width", mode_chg, 0);
        cycles(40 - DEB - 5);
        btn_next = 1'b0;
        cycles(20);
        check("hold_no_repeat", mode, 1);

        // forward wrap and backward wrap
        for (int i = 0; i < 4; i++) press(0, DEB + 3, DEB + 4);
        check("next_wrap", mode, 0);
        press(1, DEB + 3, 20);
        check("prev_wrap", mode, NM - 1);

        // en toggle, long hold does not repeat
        @(negedge clk);
        btn_en = 1'b1;
        cycles(200);
        check("en_held", en, 1);
        btn_en = 1'b0;
        cycles(20);
        check("en_after_release", en, 1);
        press(2, DEB + 3, 20);
        check("en_second", en, 0);

        // simultaneous next+prev cancel
        saved = m_mode;
        @(negedge clk);
        btn_next = 1'b1; btn_prev = 1'b1;
        cycles(DEB + 3);
        btn_next = 1'b0; btn_prev = 1'b0;
        cycles(20);
        check("both_no_step", mode, saved);

        // release bounce inside DISARM: one step only
        saved = m_mode;
        press(0, DEB + 3, 2);
        press(0, DEB + 3, 20);
        check("bounce_one_step", mode, (saved + 1) % NM);

        // auto-advance
        press(2, DEB + 3, 20);
        @(negedge clk);
        auto_sel = 1'b1;
        n = 0;
        repeat (32) begin
            @(negedge clk);
            if (mode_chg === 1'b1) n++;
        end
        check("auto_steps", n, 4);

        // make a next press land on an auto tick
        tgt = ((AP - DEB - 4) % AP + AP) % AP;
        k = 0;
        while (m_since != tgt && k < 4 * AP) begin
            @(negedge clk);
            k++;
        end
        check("coincide_sync", m_since, tgt);
        btn_next = 1'b1;
        cycles(DEB + 3);
        btn_next = 1'b0;
        cycles(30);

        @(negedge clk);
        auto_sel = 1'b0;
        cycles(3);
        saved = m_mode;
        cycles(30);
        check("auto_stop", mode, saved);

        // auto_sel with en=0: no stepping
        press(2, DEB + 3, 10);
        @(negedge clk);
        auto_sel = 1'b1;
        saved = m_mode;
        cycles(30);
        check("auto_gated_by_en", mode, saved);
        auto_sel = 1'b0;

        // mid-run reset from mode 3 / en 1, with a press in flight
        if (m_en == 0) press(2, DEB + 3, 20);
        k = 0;
        while (m_mode != 3 && k < 10) begin
            press(0, DEB + 3, 20);
            k++;
        end
        check("pre_reset_mode", mode, 3);
        check("pre_reset_en", en, 1);
        @(negedge clk);
        btn_next = 1'b1;
        cycles(3);
        do_reset();
        cycles(20);
        check("reset_discard_press", mode, 0);

        // randomized phase
        for (int i = 0; i < 3; i++) begin
            rem[i] = $urandom_range(1, 3 * DEB);
            lvl[i] = 1'b0;
        end
        repeat (4000) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rem[i] == 0) begin
                    lvl[i] = ~lvl[i];
                    rem[i] = $urandom_range(1, 3 * DEB);
                end
                rem[i]--;
                set_btn(i, lvl[i]);
            end
            if ($urandom_range(0, 99) == 0) auto_sel = ~auto_sel;
        end

        // drain
        @(negedge clk);
        btn_next = 1'b0; btn_prev = 1'b0; btn_en = 1'b0; auto_sel = 1'b0;
        cycles(30);
        check("drain_mode_q", mq.size(), 0);
        check("drain_en_q", eq.size(), 0);
        check("drain_press_q", pq.size(), 0);
        check("final_mode", mode, m_mode);
        check("final_en", en, m_en);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
